data_bus_initiator: RTL and testbench

Core-side initiator for the data memory bus: accepts load/store requests from the execute stage, drives `address`/`write_data`/`byte_enable`/`read_enable`/`write_enable` toward the data memory bus, honours `wait_req`, and tracks in-flight reads. Returned words, which arrive in order with `valid`, are aligned and sign/zero-extended into register-file format. The block sits between the core pipeline and the bus responder and supports any fixed responder latency, including 0, with up to `MAX_OUTSTANDING` reads in flight.

---
 rtl/data_bus_initiator.sv | 177 +++++++++++++++++
 tb/tb_data_bus_initiator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_initiator.sv
// data_bus_initiator
//   Core-side initiator for the data memory bus. Turns execute-stage load/store
//   requests into bus strobes, tracks in-flight reads in an in-order tag FIFO,
//   and formats returned words (lane shift + sign/zero extension) into
//   register-file format. Misaligned/illegal requests produce an error response
//   once the bus has drained.
//
// Ports
//   clock, reset                  core clock, asynchronous active-low reset
//   req_valid/ready/write         core request handshake and direction
//   req_funct3/addr/wdata         access size/signedness, byte address, store data
//   resp_valid/data/error         registered load result or error pulse
//   address/write_data            bus address and lane-replicated store data
//   byte_enable                   bus lane mask
//   read_enable/write_enable      bus strobes
//   wait_req                      responder stall
//   valid/read_data               in-order read return
module data_bus_initiator #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [3:0]  byte_enable,
    output logic        read_enable,
    output logic        write_enable,
    input  logic        wait_req,
    input  logic        valid,
    input  logic [31:0] read_data
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
    } tag_t;

    tag_t              tag_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              err_pend;

    logic              legal;
    logic              issue;
    logic              read_accept;
    logic              write_accept;
    logic              err_accept;
    logic              bypass;
    logic              resp_take;
    logic              push;
    logic              pop;
    tag_t              req_tag;
    tag_t              resp_tag;
    logic [31:0]       shifted;
    logic [31:0]       formatted;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request decode and bus-side outputs
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr[0];
            3'b010:  legal = (req_addr[1:0] == 2'b00);
            3'b100:  legal = ~req_write;
            3'b101:  legal = ~req_write & ~req_addr[0];
            default: legal = 1'b0;
        endcase

        // reset gates the strobes so they are low while reset is held
        issue = reset & req_valid & legal & ~err_pend &
                (req_write | (count < CNT_W'(MAX_OUTSTANDING)));

        read_enable  = issue & ~req_write;
        write_enable = issue &  req_write;
        read_accept  = read_enable  & ~wait_req;
        write_accept = write_enable & ~wait_req;

        // errors wait until no read is in flight or returning, keeping responses in order
        err_accept = reset & req_valid & ~legal & ~err_pend & (count == '0) & ~valid;
        req_ready  = read_accept | write_accept | err_accept;

        address = req_addr;
        case (req_funct3[1:0])
            2'b00: begin
                byte_enable = 4'b0001 << req_addr[1:0];
                write_data  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_enable = 4'b0011 << req_addr[1:0];
                write_data  = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_enable = 4'b1111;
                write_data  = req_wdata;
            end
        endcase
    end

    // Read-return tracking and formatting
    always_comb begin
        req_tag.funct3 = req_funct3;
        req_tag.lane   = req_addr[1:0];

        // zero-latency responder: the tag being issued is the one returning
        bypass    = read_accept & valid & (count == '0);
        pop       = valid & (count != '0);
        resp_take = pop | bypass;
        push      = read_accept & ~bypass;

        resp_tag = bypass ? req_tag : tag_fifo[rd_ptr];
        shifted  = read_data >> {resp_tag.lane, 3'b000};

        case (resp_tag.funct3)
            3'b000:  formatted = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  formatted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  formatted = {24'b0, shifted[7:0]};
            3'b101:  formatted = {16'b0, shifted[15:0]};
            default: formatted = read_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            tag_fifo[wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_data  <= '0;
            err_pend   <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            resp_valid <= resp_take | err_accept;
            resp_error <= err_accept;
            resp_data  <= resp_take ? formatted : '0;
            err_pend   <= err_accept;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({read_accept, resp_take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A return with nothing in flight is dropped; flag it in simulation.
    orphan_valid: assert property (@(posedge clock) disable iff (!reset)
        !(valid && count == '0 && !read_accept));

endmodule

// File: tb/tb_data_bus_initiator.sv
module tb_data_bus_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        read_enable;
    logic        write_enable;
    logic        wait_req = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] read_data = 32'h0;

    data_bus_initiator #(.MAX_OUTSTANDING(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .address(address), .write_data(write_data), .byte_enable(byte_enable),
        .read_enable(read_enable), .write_enable(write_enable),
        .wait_req(wait_req), .valid(valid), .read_data(read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] wdo;
    } vec_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    logic        got_ready, got_re, got_we;
    int unsigned ready_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h400) return 32'h80112233;
        return 32'h6C3A9E15 ^ {a[17:2], a[17:2]};
    endfunction

    function automatic logic [31:0] exp_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            3'b001: return h[15] ? {16'hFFFF, h} : {16'h0, h};
            3'b100: return {24'h0, b};
            3'b101: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // One clock cycle: entered at a negedge with inputs already driven.
    task automatic tick();
        exp_t e;
        #1;
        if (read_enable && !wait_req) rsp_q.push_back('{cyc + lat, mem_word(address)});
        valid = 1'b0;
        read_data = 32'h0;
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            valid = 1'b1;
            read_data = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        #1;
        got_ready = req_ready;
        got_re = read_enable;
        got_we = write_enable;
        if (req_ready) begin
            ready_cyc = cyc;
            if (!req_write && read_enable)
                exp_q.push_back('{1'b0, exp_fmt(req_funct3, req_addr[1:0], mem_word(req_addr)),
                                  cyc + lat + 1});
            else if (!read_enable && !write_enable)
                exp_q.push_back('{1'b1, 32'h0, cyc + 1});
        end
        @(posedge clock);
        cyc++;
        #1;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp actual=resp_valid 1 data=%h required=no response", resp_data);
            end else begin
                e = exp_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_error", 32'(resp_error), 32'(e.err));
                check("resp_cycle", cyc, e.cyc);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_resp actual=none required=data %h at cycle %0d", exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int unsigned maxw);
        int unsigned n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = d;
        got_ready = 1'b0;
        while (!got_ready && n < maxw) begin
            tick();
            n++;
        end
        if (!got_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout actual=not accepted required=accepted within %0d cycles", maxw);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        req_valid = 1'b0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
    endtask

    vec_t        vt[15];
    int unsigned acc[4];
    int unsigned held;

    initial begin
        vt[0]  = '{1'b1, 3'b000, 32'h2001, 32'h000000A5, 1'b1, 4'b0010, 32'hA5A5A5A5};
        vt[1]  = '{1'b1, 3'b001, 32'h1002, 32'hABCD1234, 1'b1, 4'b1100, 32'h12341234};
        vt[2]  = '{1'b1, 3'b010, 32'h3000, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF};
        vt[3]  = '{1'b1, 3'b000, 32'h2003, 32'h00000011, 1'b1, 4'b1000, 32'h11111111};
        vt[4]  = '{1'b1, 3'b001, 32'h1000, 32'h00005678, 1'b1, 4'b0011, 32'h56785678};
        vt[5]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        1'b1, 4'b1000, 32'h0};
        vt[6]  = '{1'b0, 3'b101, 32'h1002, 32'h0,        1'b1, 4'b1100, 32'h0};
        vt[7]  = '{1'b0, 3'b001, 32'h1001, 32'h0,        1'b0, 4'b0000, 32'h0};
        vt[8]  = '{1'b0, 3'b010, 32'h1002, 32'h0,        1'b0, 4'b0000, 32'h0};
        vt[9]  = '{1'b1, 3'b100, 32'h1000, 32'h0,        1'b0, 4'b0000, 32'h0};
        vt[10] = '{1'b0, 3'b011, 32'h1000, 32'h0,        1'b0, 4'b0000, 32'h0};
        vt[11] = '{1'b0, 3'b100, 32'h1001, 32'h0,        1'b1, 4'b0010, 32'h0};
        vt[12] = '{1'b0, 3'b010, 32'h1004, 32'h0,        1'b1, 4'b1111, 32'h0};
        vt[13] = '{1'b0, 3'b110, 32'h1000, 32'h0,        1'b0, 4'b0000, 32'h0};
        vt[14] = '{1'b1, 3'b010, 32'h2001, 32'h0,        1'b0, 4'b0000, 32'h0};

        // reset state with a request already presented
        req_valid = 1'b1;
        req_addr = 32'h1000;
        #2;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_read_enable", 32'(read_enable), 32'd0);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // table: decode, lanes, strobes, acceptance from idle
        lat = 1;
        for (int unsigned i = 0; i < 15; i++) begin
            req_valid = 1'b1;
            req_write = vt[i].w;
            req_funct3 = vt[i].f3;
            req_addr = vt[i].addr;
            req_wdata = vt[i].wd;
            #1;
            check("vec_read_enable", 32'(read_enable), 32'(vt[i].legal & ~vt[i].w));
            check("vec_write_enable", 32'(write_enable), 32'(vt[i].legal & vt[i].w));
            if (vt[i].legal) check("vec_byte_enable", 32'(byte_enable), 32'(vt[i].be));
            if (vt[i].legal && vt[i].w) check("vec_write_data", write_data, vt[i].wdo);
            tick();
            check("vec_ready", 32'(got_ready), 32'd1);
            drain();
        end

        // zero-latency responder: LB at 0x1003, then back-to-back bypass loads
        lat = 0;
        do_req(1'b0, 3'b000, 32'h1003, 32'h0, 4);
        do_req(1'b0, 3'b100, 32'h1000, 32'h0, 4);
        do_req(1'b0, 3'b101, 32'h1002, 32'h0, 4);
        do_req(1'b0, 3'b001, 32'h2002, 32'h0, 4);
        drain();

        // latency 2: four LW back to back
        lat = 2;
        for (int unsigned i = 0; i < 4; i++) begin
            do_req(1'b0, 3'b010, 32'h1000 + 32'(4 * i), 32'h0, 4);
            acc[i] = ready_cyc;
        end
        for (int unsigned i = 1; i < 4; i++) check("b2b_issue_gap", acc[i] - acc[i-1], 32'd1);
        drain();

        // wait_req stall for 3 cycles
        lat = 1;
        wait_req = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h1008;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", 32'(got_ready), 32'd0);
            check("stall_strobe", 32'(got_re), 32'd1);
            check("stall_addr", address, 32'h1008);
        end
        wait_req = 1'b0;
        tick();
        check("stall_release_ready", 32'(got_ready), 32'd1);
        drain();

        // misaligned LW held until the in-flight read has returned
        lat = 3;
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, 4);
        req_valid = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h1001;
        held = 0;
        got_ready = 1'b0;
        while (!got_ready && held < 12) begin
            tick();
            check("err_no_strobe", 32'(got_re | got_we), 32'd0);
            if (!got_ready) held++;
        end
        check("err_held_cycles", held, 32'd3);
        drain();

        // reset with three reads in flight
        lat = 5;
        for (int unsigned i = 0; i < 3; i++) do_req(1'b0, 3'b010, 32'h1000 + 32'(4 * i), 32'h0, 4);
        reset = 1'b0;
        req_valid = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h100C;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_read_enable", 32'(read_enable), 32'd0);
        check("mid_rst_resp_data", resp_data, 32'h0);
        rsp_q.delete();
        exp_q.delete();
        tick();
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        for (int unsigned i = 0; i < 10; i++) tick();
        lat = 1;
        do_req(1'b0, 3'b000, 32'h1003, 32'h0, 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
